// File: rtl/pipeline_pkg.sv
// Shared definitions for the ID-stage hazard sequencer.
//   REG_ZERO            : hard-wired zero register, never a hazard source
//   MD_LATENCY_DEFAULT  : default EX occupancy of a mult/div op
//   md_state_t          : mult/div tracker state encoding
package pipeline_pkg;

   localparam logic [4:0] REG_ZERO           = 5'd0;
   localparam int         MD_LATENCY_DEFAULT = 4;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_WAIT = 1'b1
   } md_state_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks occupancy of the multi-cycle mult/div unit.
// Ports:
//   Clk        : system clock, rising edge
//   Reset      : asynchronous, active-high reset
//   IDEX_IsMD  : mult/div op is in its first EX cycle
//   MD_Busy    : unit still occupied, HI/LO not yet ready
//
// state   | meaning
// --------+---------------------------------------------------------
// MD_IDLE | unit free, HI/LO readable
// MD_WAIT | op in flight, md_cnt counts remaining busy cycles minus 1
module md_busy_tracker
   import pipeline_pkg::*;
#(
   parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
   input  logic Clk,
   input  logic Reset,
   input  logic IDEX_IsMD,
   output logic MD_Busy
);

   // The first EX cycle is spent in MD_IDLE, and the terminal-count cycle
   // is still busy, hence the load value of latency minus two.
   localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 2);

   md_state_t  state;
   logic [3:0] md_cnt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= MD_IDLE;
         md_cnt <= 4'd0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (IDEX_IsMD) begin
                  state  <= MD_WAIT;
                  md_cnt <= MD_LOAD;
               end
            end
            MD_WAIT: begin
               if (md_cnt == 4'd0) begin
                  state <= MD_IDLE;
               end else begin
                  md_cnt <= md_cnt - 4'd1;
               end
            end
            default: begin
               state  <= MD_IDLE;
               md_cnt <= 4'd0;
            end
         endcase
      end
   end

   assign MD_Busy = (state == MD_WAIT);

   // A new mult/div cannot issue while busy: the HI/LO hazard holds it in ID.
   a_no_md_while_busy : assert property (
      @(posedge Clk) disable iff (Reset) !(state == MD_WAIT && IDEX_IsMD)
   );

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer beside the ID stage: load-use bubble,
// mult/div HI/LO wait, taken-branch flush, and a saturating stall counter.
// Ports:
//   Clk, Reset                     : clock (rising edge), async active-high reset
//   IDEX_MemRead, IDEX_rt          : load in EX and its destination
//   IDEX_IsMD                      : mult/div in its first EX cycle
//   IFID_rs, IFID_rt, IFID_UsesRt  : source fields of the ID instruction
//   IFID_UsesHiLo                  : ID instruction needs HI/LO
//   BranchTaken                    : branch resolved taken in EX
//   PCWrite, IFID_Write            : fetch / IF-ID enables
//   IDEX_Bubble, IFID_Flush        : bubble into ID/EX, nop into IF/ID
//   MD_Busy                        : mult/div unit occupied
//   StallCycles                    : saturating count of stall cycles
module hazard_stall_controller
   import pipeline_pkg::*;
#(
   parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
   parameter int CNT_W      = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_rt,
   input  logic             IDEX_IsMD,
   input  logic [4:0]       IFID_rs,
   input  logic [4:0]       IFID_rt,
   input  logic             IFID_UsesRt,
   input  logic             IFID_UsesHiLo,
   input  logic             BranchTaken,
   output logic             PCWrite,
   output logic             IFID_Write,
   output logic             IDEX_Bubble,
   output logic             IFID_Flush,
   output logic             MD_Busy,
   output logic [CNT_W-1:0] StallCycles
);

   logic load_use;
   logic md_haz;
   logic stall;

   md_busy_tracker #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md_busy_tracker (
      .Clk       (Clk),
      .Reset     (Reset),
      .IDEX_IsMD (IDEX_IsMD),
      .MD_Busy   (MD_Busy)
   );

   assign load_use = IDEX_MemRead && (IDEX_rt != REG_ZERO) &&
                     ((IDEX_rt == IFID_rs) || (IFID_UsesRt && (IDEX_rt == IFID_rt)));
   assign md_haz   = MD_Busy && IFID_UsesHiLo;

   // A taken branch makes the ID instruction wrong-path, so its hazards are moot.
   assign stall = !BranchTaken && (load_use || md_haz);

   always_comb begin
      PCWrite     = 1'b1;
      IFID_Write  = 1'b1;
      IDEX_Bubble = 1'b0;
      IFID_Flush  = 1'b0;
      if (BranchTaken) begin
         IFID_Flush  = 1'b1;
         IDEX_Bubble = 1'b1;
      end else if (stall) begin
         PCWrite     = 1'b0;
         IFID_Write  = 1'b0;
         IDEX_Bubble = 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         StallCycles <= '0;
      end else if (stall && !(&StallCycles)) begin
         StallCycles <= StallCycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       IDEX_MemRead;
   logic [4:0] IDEX_rt;
   logic       IDEX_IsMD;
   logic [4:0] IFID_rs;
   logic [4:0] IFID_rt;
   logic       IFID_UsesRt;
   logic       IFID_UsesHiLo;
   logic       BranchTaken;

   logic       PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, MD_Busy;
   logic [7:0] StallCycles;
   logic       PCWrite4, IFID_Write4, IDEX_Bubble4, IFID_Flush4, MD_Busy4;
   logic [3:0] StallCycles4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 Clk = ~Clk;

   hazard_stall_controller #(.MD_LATENCY(4), .CNT_W(8)) dut (
      .Clk(Clk), .Reset(Reset),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt), .IDEX_IsMD(IDEX_IsMD),
      .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_UsesRt(IFID_UsesRt),
      .IFID_UsesHiLo(IFID_UsesHiLo), .BranchTaken(BranchTaken),
      .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
      .IFID_Flush(IFID_Flush), .MD_Busy(MD_Busy), .StallCycles(StallCycles)
   );

   hazard_stall_controller #(.MD_LATENCY(4), .CNT_W(4)) dut4 (
      .Clk(Clk), .Reset(Reset),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt), .IDEX_IsMD(IDEX_IsMD),
      .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_UsesRt(IFID_UsesRt),
      .IFID_UsesHiLo(IFID_UsesHiLo), .BranchTaken(BranchTaken),
      .PCWrite(PCWrite4), .IFID_Write(IFID_Write4), .IDEX_Bubble(IDEX_Bubble4),
      .IFID_Flush(IFID_Flush4), .MD_Busy(MD_Busy4), .StallCycles(StallCycles4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush packed for one comparison
   function automatic logic [3:0] ctl();
      return {PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush};
   endfunction

   localparam logic [3:0] CTL_RUN    = 4'b1100;
   localparam logic [3:0] CTL_STALL  = 4'b0010;
   localparam logic [3:0] CTL_BRANCH = 4'b1111;

   task automatic clear_inputs();
      IDEX_MemRead  = 1'b0;
      IDEX_rt       = 5'd0;
      IDEX_IsMD     = 1'b0;
      IFID_rs       = 5'd0;
      IFID_rt       = 5'd0;
      IFID_UsesRt   = 1'b0;
      IFID_UsesHiLo = 1'b0;
      BranchTaken   = 1'b0;
   endtask

   // Step to the next falling edge (inputs change there), then settle.
   task automatic next_cycle();
      @(negedge Clk);
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      Reset = 1'b1;
      #2;
      check("reset_ctl",   32'(ctl()), 32'(CTL_RUN));
      check("reset_busy",  32'(MD_Busy), 32'd0);
      check("reset_cnt",   32'(StallCycles), 32'd0);
      check("reset_cnt4",  32'(StallCycles4), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;

      // load-use on rs
      next_cycle();
      IDEX_MemRead = 1'b1; IDEX_rt = 5'd8; IFID_rs = 5'd8;
      #1 check("lu_rs_ctl", 32'(ctl()), 32'(CTL_STALL));
      next_cycle();
      #1 check("lu_after_ctl", 32'(ctl()), 32'(CTL_RUN));
      check("lu_after_cnt", 32'(StallCycles), 32'd1);

      // load to $0 is never a hazard
      next_cycle();
      IDEX_MemRead = 1'b1; IDEX_rt = 5'd0; IFID_rs = 5'd0;
      #1 check("lu_r0_ctl", 32'(ctl()), 32'(CTL_RUN));

      // rt match but rt not read
      next_cycle();
      IDEX_MemRead = 1'b1; IDEX_rt = 5'd9; IFID_rs = 5'd3; IFID_rt = 5'd9;
      #1 check("lu_rt_unused_ctl", 32'(ctl()), 32'(CTL_RUN));

      // rt match with rt read
      next_cycle();
      IDEX_MemRead = 1'b1; IDEX_rt = 5'd9; IFID_rs = 5'd3; IFID_rt = 5'd9;
      IFID_UsesRt = 1'b1;
      #1 check("lu_rt_used_ctl", 32'(ctl()), 32'(CTL_STALL));

      // register match but not a load
      next_cycle();
      IDEX_rt = 5'd9; IFID_rs = 5'd9;
      #1 check("no_load_ctl", 32'(ctl()), 32'(CTL_RUN));
      check("cnt_after_rt", 32'(StallCycles), 32'd2);

      // mult/div: issue, then HI/LO reader held for three cycles
      next_cycle();
      IDEX_IsMD = 1'b1;
      #1 check("md_issue_busy", 32'(MD_Busy), 32'd0);
      check("md_issue_ctl", 32'(ctl()), 32'(CTL_RUN));
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         IFID_UsesHiLo = 1'b1;
         #1 check($sformatf("md_wait%0d_busy", i), 32'(MD_Busy), 32'd1);
         check($sformatf("md_wait%0d_ctl", i), 32'(ctl()), 32'(CTL_STALL));
      end
      next_cycle();
      IFID_UsesHiLo = 1'b1;
      #1 check("md_done_busy", 32'(MD_Busy), 32'd0);
      check("md_done_ctl", 32'(ctl()), 32'(CTL_RUN));
      check("md_done_cnt", 32'(StallCycles), 32'd5);

      // busy unit but ID does not touch HI/LO: no stall
      next_cycle();
      IDEX_IsMD = 1'b1;
      next_cycle();
      #1 check("md_nohilo_busy", 32'(MD_Busy), 32'd1);
      check("md_nohilo_ctl", 32'(ctl()), 32'(CTL_RUN));
      // branch overrides HI/LO hazard while the unit keeps counting
      next_cycle();
      IFID_UsesHiLo = 1'b1; BranchTaken = 1'b1;
      #1 check("br_md_ctl", 32'(ctl()), 32'(CTL_BRANCH));
      next_cycle();
      IFID_UsesHiLo = 1'b1;
      #1 check("br_md_busy_last", 32'(MD_Busy), 32'd1);
      check("br_md_ctl_last", 32'(ctl()), 32'(CTL_STALL));
      next_cycle();
      #1 check("br_md_idle", 32'(MD_Busy), 32'd0);
      check("br_md_cnt", 32'(StallCycles), 32'd6);

      // branch together with load-use
      next_cycle();
      IDEX_MemRead = 1'b1; IDEX_rt = 5'd8; IFID_rs = 5'd8; BranchTaken = 1'b1;
      #1 check("br_lu_ctl", 32'(ctl()), 32'(CTL_BRANCH));
      next_cycle();
      #1 check("br_lu_cnt", 32'(StallCycles), 32'd6);

      // asynchronous reset in the first busy cycle (counter at 2)
      next_cycle();
      IDEX_IsMD = 1'b1;
      next_cycle();
      IFID_UsesHiLo = 1'b1;
      #1 check("rst_pre_busy", 32'(MD_Busy), 32'd1);
      check("rst_pre_ctl", 32'(ctl()), 32'(CTL_STALL));
      #1 Reset = 1'b1;
      #1 check("rst_mid_busy", 32'(MD_Busy), 32'd0);
      check("rst_mid_ctl", 32'(ctl()), 32'(CTL_RUN));
      check("rst_mid_cnt", 32'(StallCycles), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      IFID_UsesHiLo = 1'b1;
      #1 check("rst_abandon_busy", 32'(MD_Busy), 32'd0);
      next_cycle();
      #1 check("rst_abandon_busy2", 32'(MD_Busy), 32'd0);

      // 20 back-to-back load-use stalls: 4-bit counter saturates at 15
      for (int i = 0; i < 20; i++) begin
         next_cycle();
         IDEX_MemRead = 1'b1; IDEX_rt = 5'd17; IFID_rs = 5'd2;
         IFID_rt = 5'd17; IFID_UsesRt = 1'b1;
      end
      #1 check("sat_ctl", 32'(ctl()), 32'(CTL_STALL));
      check("sat_cnt4_at19", 32'(StallCycles4), 32'd15);
      next_cycle();
      #1 check("sat_cnt4", 32'(StallCycles4), 32'd15);
      check("sat_cnt8", 32'(StallCycles), 32'd20);
      next_cycle();
      #1 check("sat_cnt4_hold", 32'(StallCycles4), 32'd15);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline hazard sequencer sitting beside the ID stage.
- Detects load-use hazards the forwarding network cannot cover, inserting a one-cycle bubble.
- Tracks the multi-cycle multiply/divide unit and holds dependent instructions in ID until HI/LO is ready.
- Flushes IF/ID and bubbles ID/EX on a taken branch.
- Drives PC/IFID write enables and the IDEX bubble mux; maintains a saturating stall-cycle counter for performance monitoring.

Parameters:
- MD_LATENCY, 4: EX-occupancy cycles of a mult/div op, counted from its first EX cycle (legal range 2..15).
- CNT_W, 8: width of the stall-cycle counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_rt  in  5  load destination register in EX.
- IDEX_IsMD  in  1  instruction in EX is mult/div, first EX cycle.
- IFID_rs  in  5  rs field of instruction in ID.
- IFID_rt  in  5  rt field of instruction in ID.
- IFID_UsesRt  in  1  ID instruction reads rt as a source.
- IFID_UsesHiLo  in  1  ID instruction is mult/div/mfhi/mflo.
- BranchTaken  in  1  branch resolved taken in EX this cycle.
- PCWrite  out  1  PC update enable.
- IFID_Write  out  1  IF/ID register enable.
- IDEX_Bubble  out  1  zero the control fields entering ID/EX.
- IFID_Flush  out  1  clear IF/ID to a nop.
- MD_Busy  out  1  mult/div unit occupied.
- StallCycles  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Registered state: two-state FSM (MD_IDLE, MD_WAIT), 4-bit down-counter MdCnt, StallCycles. Everything else is combinational from state and current inputs (Mealy), so stalls take effect in the detecting cycle.
- Reset (async, any time): MD_IDLE, MdCnt=0, StallCycles=0.
- Output reset values: PCWrite=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0, MD_Busy=0. An in-progress mult/div wait is abandoned.
- LoadUse = IDEX_MemRead & (IDEX_rt!=0) & ((IDEX_rt==IFID_rs) | (IFID_UsesRt & IDEX_rt==IFID_rt)).
- MdHaz = MD_Busy & IFID_UsesHiLo.
- MD_Busy = (state==MD_WAIT).
- FSM transitions:
  - MD_IDLE -> MD_WAIT when IDEX_IsMD; MdCnt loads MD_LATENCY-2.
  - MD_WAIT: MdCnt decrements each cycle. When MdCnt==0, -> MD_IDLE next edge.
  - IDEX_IsMD while already in MD_WAIT cannot occur, because MdHaz prevents issue; a verification assertion covers this.
- Priority, highest first:
  1. BranchTaken: IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, IFID_Write=1. Any LoadUse/MdHaz in ID is discarded, since the ID instruction is wrong-path. The MD FSM continues unaffected.
  2. LoadUse or MdHaz: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0.
  3. Otherwise: PCWrite=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0.
- Load-use stall lasts exactly one cycle: the next cycle has a bubble in EX, so LoadUse deasserts and the forwarding unit supplies the value from MEM/WB.
- StallCycles increments by 1 in any cycle where case 2 applies. It holds at all-ones (saturates) and does not wrap.
- Register 0 is never a hazard source.

Decomposition:
- Shared package (pipeline_pkg): constants REG_ZERO=5'd0, MD_LATENCY default, and the FSM state encoding (localparam MD_IDLE=1'b0, MD_WAIT=1'b1).
- One natural sub-module: md_busy_tracker, containing the FSM and down-counter and exporting MD_Busy.
- Hazard equations, priority mux and stall counter stay in the top module.

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_rt=8, IFID_rs=8 -> same cycle PCWrite=0, IFID_Write=0, IDEX_Bubble=1; next cycle (IDEX_MemRead=0) all normal; StallCycles=1.
- Load to $0 / non-reading rt: IDEX_rt=0 with IFID_rs=0 -> no stall. IDEX_rt=9, IFID_rt=9, IFID_UsesRt=0 -> no stall.
- Mult/div wait: pulse IDEX_IsMD (MD_LATENCY=4), then hold IFID_UsesHiLo=1 -> MD_Busy high exactly 3 cycles; PCWrite=0 for those 3 cycles, released the cycle MD_Busy falls; StallCycles=3.
- Branch vs hazard: BranchTaken=1 together with LoadUse -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, StallCycles unchanged.
- Reset mid-wait: assert Reset asynchronously during MD_WAIT with MdCnt=2 -> immediately MD_Busy=0, PCWrite=1, StallCycles=0.
- Saturation: CNT_W=4, force 20 consecutive load-use stalls -> StallCycles stops at 15.
